sha256_msg_padder: RTL and testbench



---
 rtl/sha256_pkg.sv | 20 ++
 rtl/sha256_pad_block.sv | 31 +++
 rtl/sha256_msg_padder.sv | 130 +++++++++++++
 tb/tb_sha256_msg_padder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, FSM encoding and byte-lane helper for the SHA-256 message padder.
package sha256_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int BLOCK_BITS  = 512;
    localparam int LEN_OFFSET  = 56;
    localparam logic [7:0] PAD_MARKER = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_PAD,
        ST_EMIT
    } pad_state_t;

    // Byte 0 is the most significant lane of the block.
    function automatic int lane_lsb(input int n);
        return BLOCK_BITS - 8 - 8 * n;
    endfunction

endpackage

// File: rtl/sha256_pad_block.sv
// Builds a padded block: keeps bytes below p, marker/zero at p, zero above, length in the tail.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sha256_pad_block
    import sha256_pkg::*;
(
    input  logic [BLOCK_BITS-1:0] buffer,
    input  logic [5:0]            p,
    input  logic                  marker_pending,
    input  logic [63:0]           length,
    output logic [BLOCK_BITS-1:0] block,
    output logic                  is_final
);

    always_comb begin
        is_final = (p <= 6'(LEN_OFFSET - 1));
        block    = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (6'(i) < p) begin
                block[lane_lsb(i) +: 8] = buffer[lane_lsb(i) +: 8];
            end else if (6'(i) == p) begin
                block[lane_lsb(i) +: 8] = marker_pending ? PAD_MARKER : 8'h00;
            end
            // The length only fits when the marker landed at or before byte 55.
            if (is_final && i >= LEN_OFFSET) begin
                block[lane_lsb(i) +: 8] = length[8 * (BLOCK_BYTES - 1 - i) +: 8];
            end
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Packs a byte stream into FIPS 180-4 padded 512-bit chunks with first/last flags.
// Latency: last byte at T -> chunk_valid at T+2; 64th byte of a full block at T -> T+1.
// Backpressure: chunk held stable while chunk_ready is low; in_ready is low outside FILL.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int COUNT_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    input  logic                  in_empty,
    output logic [BLOCK_BITS-1:0] chunk,
    output logic                  chunk_valid,
    input  logic                  chunk_ready,
    output logic                  chunk_first,
    output logic                  chunk_last
);

    pad_state_t             state, state_next;
    logic [5:0]             p;
    logic [COUNT_W-1:0]     bit_cnt;
    logic [BLOCK_BITS-1:0]  buffer;
    logic                   marker_pending;
    logic                   is_final;
    logic                   first_pending;
    logic                   pad_owed;
    logic [BLOCK_BITS-1:0]  pad_blk;
    logic                   pad_final;
    logic                   byte_wr;

    sha256_pad_block u_pad (
        .buffer         (buffer),
        .p              (p),
        .marker_pending (marker_pending),
        .length         (64'(bit_cnt)),
        .block          (pad_blk),
        .is_final       (pad_final)
    );

    assign in_ready    = (state == ST_FILL) && !reset;
    assign chunk_valid = (state == ST_EMIT) && !reset;
    assign chunk_first = chunk_valid && first_pending;
    assign chunk_last  = chunk_valid && is_final;
    assign chunk       = buffer;
    // An empty-message handshake carries no byte.
    assign byte_wr     = in_valid && !(in_last && in_empty);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_FILL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: begin
                if (in_valid) begin
                    if (byte_wr && p == 6'd63) state_next = ST_EMIT;
                    else if (in_last)          state_next = ST_PAD;
                end
            end
            ST_PAD: state_next = ST_EMIT;
            ST_EMIT: begin
                if (chunk_ready) begin
                    if (is_final)      state_next = ST_FILL;
                    else if (pad_owed) state_next = ST_PAD;
                    else               state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p              <= '0;
            bit_cnt        <= '0;
            buffer         <= '0;
            marker_pending <= 1'b0;
            is_final       <= 1'b0;
            first_pending  <= 1'b1;
            pad_owed       <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        if (byte_wr) begin
                            buffer[lane_lsb(int'(p)) +: 8] <= in_data;
                            p       <= p + 6'd1;
                            bit_cnt <= bit_cnt + COUNT_W'(8);
                            if (p == 6'd63) begin
                                is_final       <= 1'b0;
                                marker_pending <= in_last;
                                pad_owed       <= in_last;
                            end else if (in_last) begin
                                marker_pending <= 1'b1;
                            end
                        end else if (in_last) begin
                            marker_pending <= 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    buffer         <= pad_blk;
                    is_final       <= pad_final;
                    p              <= '0;
                    marker_pending <= 1'b0;
                    pad_owed       <= !pad_final;
                end
                ST_EMIT: begin
                    if (chunk_ready) begin
                        first_pending <= 1'b0;
                        if (is_final) begin
                            bit_cnt       <= '0;
                            p             <= '0;
                            buffer        <= '0;
                            first_pending <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: directed padding cases, backpressure, reset and random messages.
module tb_sha256_msg_padder;

    typedef logic [7:0] byte_q_t[$];

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_empty;
    logic [511:0] chunk;
    logic         chunk_valid;
    logic         chunk_ready;
    logic         chunk_first;
    logic         chunk_last;

    int vectors    = 0;
    int miscompares = 0;

    sha256_msg_padder #(.COUNT_W(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_empty    (in_empty),
        .chunk       (chunk),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_first (chunk_first),
        .chunk_last  (chunk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference: the whole padded message as a byte queue, cut into 64-byte chunks.
    task automatic build_expected(input byte_q_t msg, output logic [511:0] chunks[$]);
        logic [7:0]  pb[$];
        logic [63:0] bitlen;
        logic [511:0] c;
        pb = msg;
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56) pb.push_back(8'h00);
        bitlen = 64'(msg.size()) * 64'd8;
        for (int i = 0; i < 8; i++) pb.push_back(bitlen[63 - 8 * i -: 8]);
        chunks = {};
        for (int n = 0; n < pb.size() / 64; n++) begin
            for (int j = 0; j < 64; j++) c[511 - 8 * j -: 8] = pb[64 * n + j];
            chunks.push_back(c);
        end
    endtask

    task automatic run_msg(input byte_q_t msg, input int vpct, input int rpct);
        logic [511:0] exp_q[$];
        int len, total, sent, got, owed, it, fire_it, exp_lat, nchunks;
        bit pend;
        build_expected(msg, exp_q);
        len = msg.size();
        total = (len == 0) ? 1 : len;
        nchunks = exp_q.size();
        sent = 0; got = 0; owed = 0; it = 0; fire_it = 0; exp_lat = 0; pend = 0;
        while (got < nchunks) begin
            @(negedge clk);
            it++;
            if (it > 5000) begin
                chk("chunk_count_timeout", 512'(got), 512'(nchunks));
                break;
            end
            in_data = 8'($urandom);
            if (sent < total && int'($urandom_range(99, 0)) < vpct) begin
                in_valid = 1'b1;
                in_empty = (len == 0);
                in_last  = (sent == total - 1);
                if (len != 0) in_data = msg[sent];
            end else begin
                in_valid = 1'b0;
                in_last  = 1'($urandom);
                in_empty = 1'b0;
            end
            chunk_ready = (int'($urandom_range(99, 0)) < rpct);
            #1;
            chk("in_ready", 512'(in_ready), 512'(owed == 0));
            if (pend && chunk_valid) begin
                chk("latency", 512'(it - fire_it), 512'(exp_lat));
                pend = 0;
            end
            if (in_valid && in_ready) begin
                int k = sent;
                sent++;
                if (len == 0) begin
                    owed = nchunks; exp_lat = 2; pend = 1; fire_it = it;
                end else if (k == len - 1) begin
                    owed = nchunks - k / 64;
                    exp_lat = (k % 64 == 63) ? 1 : 2; pend = 1; fire_it = it;
                end else if (k % 64 == 63) begin
                    owed = 1; exp_lat = 1; pend = 1; fire_it = it;
                end
            end
            if (chunk_valid && chunk_ready) begin
                chk("chunk_data", chunk, exp_q[got]);
                chk("chunk_first", 512'(chunk_first), 512'(got == 0));
                chk("chunk_last", 512'(chunk_last), 512'(got == nchunks - 1));
                got++;
                owed--;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0; chunk_ready = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic last);
        int b = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; in_empty = 1'b0;
        #1;
        while (!in_ready && b < 100) begin
            @(negedge clk); #1; b++;
        end
        chk("push_ready", 512'(in_ready), 512'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    initial begin
        byte_q_t      msg;
        logic [511:0] abc_exp;
        logic [511:0] snap;
        int           w;

        abc_exp = {32'h61626380, 416'h0, 64'h18};
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        in_empty = 1'b0; chunk_ready = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'(0));
        chk("rst_chunk_valid", 512'(chunk_valid), 512'(0));
        chk("rst_chunk_first", 512'(chunk_first), 512'(0));
        chk("rst_chunk_last", 512'(chunk_last), 512'(0));
        chk("rst_chunk", chunk, 512'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 512'(in_ready), 512'(1));

        msg = {8'h61, 8'h62, 8'h63};
        run_msg(msg, 100, 100);
        msg = {};
        run_msg(msg, 100, 100);
        msg = {};
        for (int i = 0; i < 55; i++) msg.push_back(8'h00);
        run_msg(msg, 100, 100);
        msg.push_back(8'h00);
        run_msg(msg, 100, 100);
        msg = {};
        for (int i = 0; i < 64; i++) msg.push_back(8'(i));
        run_msg(msg, 100, 100);

        // Backpressure: chunk held with chunk_ready low.
        chunk_ready = 1'b0;
        push_byte(8'h61, 1'b0);
        push_byte(8'h62, 1'b0);
        push_byte(8'h63, 1'b1);
        w = 0;
        @(negedge clk); #1;
        while (!chunk_valid && w < 20) begin @(negedge clk); #1; w++; end
        chk("bp_valid", 512'(chunk_valid), 512'(1));
        chk("bp_abc_chunk", chunk, abc_exp);
        snap = chunk;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("bp_stable", chunk, snap);
            chk("bp_in_ready", 512'(in_ready), 512'(0));
            chk("bp_first_last", 512'({chunk_valid, chunk_first, chunk_last}), 512'(3'b111));
        end

        // Reset with a chunk pending, then again mid-message.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_drop_valid", 512'(chunk_valid), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_buffer_clear", chunk, 512'(0));
        chk("rst_ready_back", 512'(in_ready), 512'(1));
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(msg, 100, 100);

        for (int m = 0; m < 14; m++) begin
            int len = int'($urandom_range(140, 0));
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            run_msg(msg, int'($urandom_range(100, 50)), int'($urandom_range(100, 30)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
